gcd_swap_sequencer: RTL and testbench

- Controller plus x/y register pair that computes GCD(a,b) by subtract-and-swap on a W-bit datapath.
- Drives the datapath control strobes `init` (load), `swapxy` (exchange) and `sub` (x <= x - y) from an FSM.
- Exposes the x/y state for observation, and a start/busy/done handshake for the lab top level.
- Sits between the top-level test driver and the existing init/swap x-y register datapath; it sequences that datapath.

---
 rtl/gcd_swap_sequencer.sv | 105 ++++++++++
 tb/tb_gcd_swap_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gcd_swap_sequencer.sv
// rtl/gcd_swap_sequencer.sv - subtract-and-swap GCD controller with x/y register pair
module gcd_swap_sequencer #(
  parameter int W  = 3,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          init,
  output logic          swapxy,
  output logic          sub,
  output logic [W-1:0]  x,
  output logic [W-1:0]  y,
  output logic [CW-1:0] sub_cnt,
  output logic [CW-1:0] swap_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_SUB   = 3'd2;
  localparam logic [2:0] S_SWAP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    r_state;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_y;
  logic [W-1:0]  r_result;
  logic [CW-1:0] r_sub_cnt;
  logic [CW-1:0] r_swap_cnt;

  logic          w_accept;

  // Load strobe is gated by reset so a held start cannot pulse init during reset.
  assign w_accept = start & (r_state == S_IDLE) & ~reset;

  // Controller state, datapath registers and saturating step counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_result   <= '0;
      r_sub_cnt  <= '0;
      r_swap_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x        <= a;
            r_y        <= b;
            r_sub_cnt  <= '0;
            r_swap_cnt <= '0;
            r_state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_y == '0) begin
            // Capture on the way into DONE so result is already valid while done is high.
            r_result <= r_x;
            r_state  <= S_DONE;
          end else if (r_x < r_y) begin
            r_state <= S_SWAP;
          end else begin
            r_state <= S_SUB;
          end
        end
        S_SUB: begin
          // x >= y here, so the difference never borrows.
          r_x <= r_x - r_y;
          if (r_sub_cnt != {CW{1'b1}}) r_sub_cnt <= r_sub_cnt + CW'(1);
          r_state <= S_CHECK;
        end
        S_SWAP: begin
          r_x <= r_y;
          r_y <= r_x;
          if (r_swap_cnt != {CW{1'b1}}) r_swap_cnt <= r_swap_cnt + CW'(1);
          r_state <= S_CHECK;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign init     = w_accept;
  assign swapxy   = (r_state == S_SWAP);
  assign sub      = (r_state == S_SUB);
  assign result   = r_result;
  assign x        = r_x;
  assign y        = r_y;
  assign sub_cnt  = r_sub_cnt;
  assign swap_cnt = r_swap_cnt;

endmodule

// File: tb/tb_gcd_swap_sequencer.sv
// tb/tb_gcd_swap_sequencer.sv - directed self-checking bench for gcd_swap_sequencer
module tb_gcd_swap_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] a;
  logic [2:0] b;
  logic       busy;
  logic       done;
  logic [2:0] result;
  logic       init;
  logic       swapxy;
  logic       sub;
  logic [2:0] x;
  logic [2:0] y;
  logic [3:0] sub_cnt;
  logic [3:0] swap_cnt;

  int n_pass;
  int n_total;

  gcd_swap_sequencer #(.W(3), .CW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .init(init),
    .swapxy(swapxy), .sub(sub), .x(x), .y(y),
    .sub_cnt(sub_cnt), .swap_cnt(swap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int ref_gcd(input int p, input int q);
    int t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Present operands with start at a negedge, confirm init, and let the accept edge pass.
  task automatic accept(input logic [2:0] va, input logic [2:0] vb, input bit drop_start);
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    #1;
    chk("init_on_accept", init, 1);
    @(posedge clk);
    #1;
    if (drop_start) start = 1'b0;
  endtask

  // Count cycles after the accept edge until done; tally strobes along the way.
  task automatic wait_done(output int k, output int ns, output int nw, output int ni, output int dbl);
    logic prev;
    prev = 1'b0;
    k = 0; ns = 0; nw = 0; ni = 0; dbl = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      k++;
      ns += int'(sub);
      nw += int'(swapxy);
      ni += int'(init);
      if (prev && done) dbl++;
      prev = done;
      if (done) break;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] va, input logic [2:0] vb,
                     input int e_res, input int e_sub, input int e_swap, input int e_lat);
    int k, ns, nw, ni, dbl;
    accept(va, vb, 1'b1);
    wait_done(k, ns, nw, ni, dbl);
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_latency"}, k, e_lat);
    chk({tag, "_result"}, result, e_res);
    chk({tag, "_sub_cnt"}, sub_cnt, e_sub);
    chk({tag, "_swap_cnt"}, swap_cnt, e_swap);
    chk({tag, "_sub_cycles"}, ns, e_sub);
    chk({tag, "_swap_cycles"}, nw, e_swap);
    chk({tag, "_init_while_busy"}, ni, 0);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_result_held"}, result, e_res);
  endtask

  initial begin
    int k, ns, nw, ni, dbl;
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_init", init, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_result", result, 0);
    reset = 1'b0;

    // Nominal 6,4: SUB,SWAP,SUB,SUB,SWAP -> 2*(3+2)+2.
    run("nom64", 3'd6, 3'd4, 2, 3, 2, 12);

    // Reset three cycles into a run clears everything, including the previous result.
    accept(3'd6, 3'd4, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_init", init, 0);
    chk("mid_swapxy", swapxy, 0);
    chk("mid_sub", sub, 0);
    chk("mid_x", x, 0);
    chk("mid_y", y, 0);
    chk("mid_result", result, 0);
    chk("mid_sub_cnt", sub_cnt, 0);
    chk("mid_swap_cnt", swap_cnt, 0);
    run("after_rst", 3'd6, 3'd4, 2, 3, 2, 12);

    run("chain71", 3'd7, 3'd1, 1, 7, 1, 18);
    run("b_zero", 3'd5, 3'd0, 5, 0, 0, 2);
    run("a_zero", 3'd0, 3'd5, 5, 0, 1, 4);
    run("both_zero", 3'd0, 3'd0, 0, 0, 0, 2);

    // start held high: second operands appear while busy and must not be captured.
    accept(3'd6, 3'd4, 1'b0);
    a = 3'd3;
    b = 3'd3;
    wait_done(k, ns, nw, ni, dbl);
    chk("hold_lat1", k, 12);
    chk("hold_res1", result, 2);
    chk("hold_sub1", sub_cnt, 3);
    chk("hold_swap1", swap_cnt, 2);
    chk("hold_no_init_busy", ni, 0);
    @(negedge clk);
    chk("hold_idle_busy", busy, 0);
    chk("hold_reaccept_init", init, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(k, ns, nw, ni, dbl);
    chk("hold_lat2", k, 6);
    chk("hold_res2", result, 3);
    chk("hold_sub2", sub_cnt, 1);
    chk("hold_swap2", swap_cnt, 1);

    // Exhaustive sweep against a Euclid reference.
    for (int ia = 0; ia < 8; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        accept(3'(ia), 3'(ib), 1'b1);
        wait_done(k, ns, nw, ni, dbl);
        chk($sformatf("sweep_done_%0d_%0d", ia, ib), done, 1);
        chk($sformatf("sweep_res_%0d_%0d", ia, ib), result, ref_gcd(ia, ib));
        chk($sformatf("sweep_lat_%0d_%0d", ia, ib), k, 2 * (ns + nw) + 2);
        @(negedge clk);
        chk($sformatf("sweep_idle_%0d_%0d", ia, ib), {busy, done}, 2'b00);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
